// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response channel,
// redirect input and the decode-facing instruction channel.
// master = fetch unit side, slave = memory/decode/branch-resolution side.
interface fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [6:0]  instr_op;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus4;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      input  redirect, redirect_pc,
      output instr_valid, instr, instr_op, instr_pc, instr_pc_plus4,
      input  instr_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      output redirect, redirect_pc,
      input  instr_valid, instr, instr_op, instr_pc, instr_pc_plus4,
      output instr_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order word requests, buffers returned words for decode.
// Latency: memory response to instr_valid is 1 cycle; request valid depends on registered state only.
// Backpressure: credit-limited, buffered + outstanding words never exceed FIFO_DEPTH; redirect flushes all.
//
// Ports: clk/reset (sync, active-high); bus (fetch_unit_if.master) carries the imem
// request/response channel, redirect/redirect_pc and the instr/instr_op/instr_pc/
// instr_pc_plus4 channel to decode.
// Optional macro FETCH_PERF_EN adds saturating perf_fetched/perf_flushed/perf_starved outputs.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]  perf_fetched,
   output logic [31:0]  perf_flushed,
   output logic [31:0]  perf_starved
`endif
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0]   DEPTH_W  = (CW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic          init_q;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] stale_q, stale_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] iss_ptr_q, iss_ptr_d, ret_ptr_q, ret_ptr_d;
   logic [31:0]   data_q [FIFO_DEPTH];
   logic [31:0]   pc_q   [FIFO_DEPTH];
   // Address of every issued request, consumed in order as responses return.
   logic [31:0]   rec_q  [FIFO_DEPTH];

   logic req_hs, resp, drop, push, pop, head_vld;
   logic rpc_lsb_unused;

   assign rpc_lsb_unused = |bus.redirect_pc[1:0];

   // init_q keeps requests off while reset is held and for the first cycle after it.
   assign bus.imem_req_valid = !init_q && (({1'b0, count_q} + {1'b0, out_q}) < DEPTH_W);
   assign bus.imem_req_addr  = fetch_pc_q;

   assign req_hs = bus.imem_req_valid && bus.imem_req_ready;
   assign resp   = bus.imem_resp_valid;
   assign drop   = resp && (stale_q != '0);
   // Redirect wins: any same-cycle push or pop is cancelled by the clear.
   assign push   = resp && !drop && !bus.redirect;
   assign pop    = head_vld && bus.instr_ready && !bus.redirect;

   assign head_vld           = (count_q != '0);
   assign bus.instr_valid    = head_vld;
   assign bus.instr          = head_vld ? data_q[rd_ptr_q] : '0;
   assign bus.instr_op       = bus.instr[6:0];
   assign bus.instr_pc       = head_vld ? pc_q[rd_ptr_q] : '0;
   assign bus.instr_pc_plus4 = head_vld ? (pc_q[rd_ptr_q] + 32'd4) : '0;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      out_d      = out_q + CW'(req_hs) - CW'(resp);
      stale_d    = stale_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      iss_ptr_d  = iss_ptr_q + PW'(req_hs);
      ret_ptr_d  = ret_ptr_q + PW'(resp);
      if (bus.redirect) begin
         fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         // Everything still in flight after this edge belongs to the old path.
         stale_d    = out_d;
      end else begin
         if (req_hs) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         stale_d  = stale_q - CW'(drop);
         count_d  = count_q + CW'(push) - CW'(pop);
         rd_ptr_d = rd_ptr_q + PW'(pop);
         wr_ptr_d = wr_ptr_q + PW'(push);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         init_q     <= 1'b1;
         fetch_pc_q <= RESET_PC;
         out_q      <= '0;
         stale_q    <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         iss_ptr_q  <= '0;
         ret_ptr_q  <= '0;
      end else begin
         init_q     <= 1'b0;
         fetch_pc_q <= fetch_pc_d;
         out_q      <= out_d;
         stale_q    <= stale_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         iss_ptr_q  <= iss_ptr_d;
         ret_ptr_q  <= ret_ptr_d;
      end
   end

   // Storage needs no reset: head fields are masked while the buffer is empty.
   always_ff @(posedge clk) begin
      if (!reset && req_hs) begin
         rec_q[iss_ptr_q] <= fetch_pc_q;
      end
      if (!reset && push) begin
         data_q[wr_ptr_q] <= bus.imem_resp_data;
         pc_q[wr_ptr_q]   <= rec_q[ret_ptr_q];
      end
   end

   always @(posedge clk) begin
      if (!reset) begin
         assert (!(push && !pop && count_q == FULL_CNT));
         assert (!(resp && out_q == '0));
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] fetched_q, flushed_q, starved_q;
   logic [31:0] flush_inc;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   // On redirect the whole buffer plus any arriving word are thrown away.
   assign flush_inc = bus.redirect ? (32'(count_q) + 32'(resp)) : 32'(drop);

   always_ff @(posedge clk) begin
      if (reset) begin
         fetched_q <= '0;
         flushed_q <= '0;
         starved_q <= '0;
      end else begin
         fetched_q <= sat_add(fetched_q, 32'(pop));
         flushed_q <= sat_add(flushed_q, flush_inc);
         starved_q <= sat_add(starved_q, 32'(bus.instr_ready && !head_vld));
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_flushed = flushed_q;
   assign perf_starved = starved_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   fetch_unit_if bus();
   fetch_unit_if wbus();

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_flushed, perf_starved;
   logic [31:0] w_pf, w_pfl, w_ps;
`endif

   fetch_unit #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .bus(bus)
`ifdef FETCH_PERF_EN
      , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_starved(perf_starved)
`endif
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_w (
      .clk(clk), .reset(reset), .bus(wbus)
`ifdef FETCH_PERF_EN
      , .perf_fetched(w_pf), .perf_flushed(w_pfl), .perf_starved(w_ps)
`endif
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // stimulus knobs for the current cycle
   bit          t_req_ready, t_instr_ready, t_redirect;
   logic [31:0] t_rpc;
   int          lat;

   // instruction memory behind the main instance (in-order, fixed latency)
   logic [31:0] mem_addr[$];
   int          mem_due[$];

   // reference model: in-flight requests with a stale flag, and the buffer contents
   typedef struct { logic [31:0] addr; bit stale; } infl_t;
   typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;
   infl_t       m_infl[$];
   ent_t        m_fifo[$];
   logic [31:0] m_pc;
   bit          m_init;
   int          m_fetched, m_flushed, m_starved;

   // observation logs
   logic [31:0] acc_log[$];
   logic [31:0] pop_pc_log[$];
   logic [31:0] pop_pc4_log[$];
   int          first_acc_cyc, first_vld_cyc, hs_count, dut_pops;

   // wrap-around instance: always-ready memory with 1-cycle latency, decode stalled
   bit          w_pend, w_seen;
   logic [31:0] w_pend_addr, w_first_pc, w_first_pc4;
   logic [31:0] w_acc[$];

   function automatic logic [31:0] memword(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_0F13;
   endfunction

   function automatic bit m_req_valid();
      return !m_init && ((m_fifo.size() + m_infl.size()) < 2);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compare();
      bit rv;
      rv = m_req_valid();
      chk("req_valid", 32'(bus.imem_req_valid), 32'(rv));
      if (rv) chk("req_addr", bus.imem_req_addr, m_pc);
      chk("instr_valid", 32'(bus.instr_valid), 32'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) begin
         chk("instr", bus.instr, m_fifo[0].data);
         chk("instr_op", 32'(bus.instr_op), 32'(m_fifo[0].data[6:0]));
         chk("instr_pc", bus.instr_pc, m_fifo[0].pc);
         chk("instr_pc_plus4", bus.instr_pc_plus4, m_fifo[0].pc + 32'd4);
      end else begin
         chk("instr_empty", bus.instr, 32'h0);
         chk("instr_op_empty", 32'(bus.instr_op), 32'h0);
         chk("instr_pc_empty", bus.instr_pc, 32'h0);
         chk("instr_pc4_empty", bus.instr_pc_plus4, 32'h0);
      end
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, 32'(m_fetched));
      chk("perf_flushed", perf_flushed, 32'(m_flushed));
      chk("perf_starved", perf_starved, 32'(m_starved));
`endif
      if (bus.instr_valid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (!w_seen && wbus.instr_valid === 1'b1) begin
         w_seen      = 1'b1;
         w_first_pc  = wbus.instr_pc;
         w_first_pc4 = wbus.instr_pc_plus4;
      end
   endtask

   task automatic step();
      bit          rv, hs, m_hs, m_pop, w_hs;
      logic [31:0] rd;
      infl_t       e;
      ent_t        n;
      bus.imem_req_ready = t_req_ready;
      bus.instr_ready    = t_instr_ready;
      bus.redirect       = t_redirect;
      bus.redirect_pc    = t_rpc;
      rv = !reset && mem_addr.size() > 0 && mem_due[0] <= cyc;
      rd = rv ? memword(mem_addr[0]) : 32'h0;
      bus.imem_resp_valid = rv;
      bus.imem_resp_data  = rd;
      hs = (bus.imem_req_valid === 1'b1) && t_req_ready;

      wbus.imem_req_ready  = 1'b1;
      wbus.instr_ready     = 1'b0;
      wbus.redirect        = 1'b0;
      wbus.redirect_pc     = 32'h0;
      wbus.imem_resp_valid = w_pend && !reset;
      wbus.imem_resp_data  = memword(w_pend_addr);
      w_hs = (wbus.imem_req_valid === 1'b1);
      if (!reset && w_hs && w_acc.size() < 2) w_acc.push_back(wbus.imem_req_addr);
      w_pend      = !reset && w_hs;
      w_pend_addr = wbus.imem_req_addr;

      if (reset) begin
         mem_addr.delete();
         mem_due.delete();
         m_infl.delete();
         m_fifo.delete();
         m_pc      = 32'h0000_0100;
         m_init    = 1'b1;
         m_fetched = 0;
         m_flushed = 0;
         m_starved = 0;
      end else begin
         if (rv) begin
            void'(mem_addr.pop_front());
            void'(mem_due.pop_front());
         end
         if (hs) begin
            mem_addr.push_back(bus.imem_req_addr);
            mem_due.push_back(cyc + lat);
            acc_log.push_back(bus.imem_req_addr);
            hs_count++;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
         end
         if (bus.instr_valid === 1'b1 && t_instr_ready && !t_redirect) begin
            pop_pc_log.push_back(bus.instr_pc);
            pop_pc4_log.push_back(bus.instr_pc_plus4);
            dut_pops++;
         end

         m_hs  = m_req_valid() && t_req_ready;
         m_pop = (m_fifo.size() > 0) && t_instr_ready;
         if (t_instr_ready && m_fifo.size() == 0) m_starved++;
         if (t_redirect) begin
            m_flushed += m_fifo.size() + (rv ? 1 : 0);
            if (rv && m_infl.size() > 0) void'(m_infl.pop_front());
            if (m_hs) begin
               e.addr = m_pc;
               e.stale = 1'b1;
               m_infl.push_back(e);
            end
            foreach (m_infl[i]) m_infl[i].stale = 1'b1;
            m_fifo.delete();
            m_pc = {t_rpc[31:2], 2'b00};
         end else begin
            if (m_pop) begin
               void'(m_fifo.pop_front());
               m_fetched++;
            end
            if (rv && m_infl.size() > 0) begin
               e = m_infl.pop_front();
               if (e.stale) m_flushed++;
               else begin
                  n.data = rd;
                  n.pc   = e.addr;
                  m_fifo.push_back(n);
               end
            end
            if (m_hs) begin
               e.addr = m_pc;
               e.stale = 1'b0;
               m_infl.push_back(e);
               m_pc = m_pc + 32'd4;
            end
         end
         m_init = 1'b0;
      end

      @(posedge clk);
      cyc++;
      #1;
      compare();
   endtask

   task automatic do_reset(input int n);
      acc_log.delete();
      pop_pc_log.delete();
      pop_pc4_log.delete();
      first_acc_cyc = -1;
      first_vld_cyc = -1;
      hs_count = 0;
      dut_pops = 0;
      t_redirect = 1'b0;
      t_req_ready = 1'b1;
      reset = 1'b1;
      repeat (n) step();
      reset = 1'b0;
   endtask

   initial begin
      int bad;
      bit found;
      logic [31:0] snap;
      reset = 1'b1;
      t_req_ready = 1'b1;
      t_instr_ready = 1'b1;
      t_redirect = 1'b0;
      t_rpc = 32'h0;
      lat = 1;
      w_pend = 1'b0;
      w_seen = 1'b0;
      w_pend_addr = 32'h0;
      w_first_pc = 32'h0;
      w_first_pc4 = 32'h0;
      snap = 32'h0;
      #1;

      // reset start: ready memory, 1-cycle latency, decode always ready
      do_reset(3);
      repeat (14) step();
      chk("A acc0", acc_log[0], 32'h0000_0100);
      chk("A acc1", acc_log[1], 32'h0000_0104);
      chk("A acc2", acc_log[2], 32'h0000_0108);
      chk("A first valid delay", 32'(first_vld_cyc - first_acc_cyc), 32'd2);
      chk("A pop pc0", pop_pc_log[0], 32'h0000_0100);
      chk("A pop pc1", pop_pc_log[1], 32'h0000_0104);
      chk("A pop pc4_0", pop_pc4_log[0], 32'h0000_0104);
      chk("A pop pc4_1", pop_pc4_log[1], 32'h0000_0108);
      // wrap-around instance ran alongside
      chk("W acc0", w_acc[0], 32'hFFFF_FFFC);
      chk("W acc1", w_acc[1], 32'h0000_0000);
      chk("W first pc", w_first_pc, 32'hFFFF_FFFC);
      chk("W first pc4", w_first_pc4, 32'h0000_0000);

      // backpressure: decode stalled
      do_reset(2);
      t_instr_ready = 1'b0;
      repeat (8) step();
      chk("B issued", 32'(hs_count), 32'd2);
      chk("B head pc", bus.instr_pc, 32'h0000_0100);
      t_instr_ready = 1'b1;
      step();
      t_instr_ready = 1'b0;
      chk("B popped pc", pop_pc_log[0], 32'h0000_0100);
      hs_count = 0;
      repeat (6) step();
      chk("B refill", 32'(hs_count), 32'd1);

      // redirect with two stale requests outstanding
      do_reset(2);
      lat = 3;
      t_instr_ready = 1'b1;
      repeat (3) step();
      chk("C outstanding", 32'(mem_addr.size()), 32'd2);
      t_redirect = 1'b1;
      t_rpc = 32'h0000_0203;
      step();
      t_redirect = 1'b0;
      acc_log.delete();
      pop_pc_log.delete();
      repeat (20) step();
      chk("C next addr", acc_log[0], 32'h0000_0200);
      chk("C first pc", pop_pc_log[0], 32'h0000_0200);
`ifdef FETCH_PERF_EN
      chk("C perf_flushed", perf_flushed, 32'd2);
      chk("C perf_fetched", perf_fetched, 32'(dut_pops));
      t_req_ready = 1'b0;
      repeat (8) step();
      snap = perf_starved;
      repeat (5) step();
      chk("C perf_starved delta", perf_starved - snap, 32'd5);
      t_req_ready = 1'b1;
`endif

      // redirect coinciding with a request handshake and a response
      do_reset(2);
      lat = 1;
      t_instr_ready = 1'b1;
      repeat (3) step();
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (bus.imem_req_valid === 1'b1 && mem_addr.size() > 0 && mem_due[0] <= cyc) found = 1'b1;
         else step();
      end
      chk("D corner reached", 32'(found), 32'd1);
      t_redirect = 1'b1;
      t_rpc = 32'h0000_0300;
      pop_pc_log.delete();
      step();
      t_redirect = 1'b0;
      repeat (15) step();
      bad = 0;
      foreach (pop_pc_log[i]) if (pop_pc_log[i] < 32'h300 || pop_pc_log[i] >= 32'h400) bad++;
      chk("D old pc seen", 32'(bad), 32'd0);
      chk("D first pc", pop_pc_log[0], 32'h0000_0300);

      // back-to-back redirects
      do_reset(2);
      lat = 2;
      repeat (3) step();
      t_redirect = 1'b1;
      t_rpc = 32'h0000_0400;
      step();
      t_rpc = 32'h0000_0502;
      step();
      t_redirect = 1'b0;
      pop_pc_log.delete();
      repeat (15) step();
      chk("E first pc", pop_pc_log[0], 32'h0000_0500);
      chk("E second pc", pop_pc_log[1], 32'h0000_0504);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the decode/control stage. It owns the PC, issues in-order word requests to instruction memory over a valid/ready request channel, and buffers returned words in a small FIFO. It presents one instruction per handshake to decode, with `instr_op` wired straight to the main decoder's `op` input. A redirect from branch/jump resolution flushes everything in flight and restarts fetch at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries and maximum outstanding-plus-buffered words; power of two, ≥2.

Ports:
- clk, input, 1, sole clock, rising edge.
- reset, input, 1, synchronous, active-high.
- imem_req_valid, output, 1, request address valid.
- imem_req_ready, input, 1, memory accepts request.
- imem_req_addr, output, 32, word-aligned fetch address.
- imem_resp_valid, input, 1, response word valid; responses return in order, ≥1 cycle after acceptance.
- imem_resp_data, input, 32, returned instruction.
- redirect, input, 1, flush and restart fetch.
- redirect_pc, input, 32, restart address; bits [1:0] ignored, forced to 00.
- instr_valid, output, 1, FIFO head valid.
- instr_ready, input, 1, decode consumes head.
- instr, output, 32, head instruction.
- instr_op, output, 7, instr[6:0]; feeds the main decoder's `op`.
- instr_pc, output, 32, address of head instruction.
- instr_pc_plus4, output, 32, instr_pc + 4, modulo 2^32.

Behaviour:
- **Reset:**
  - fetch_pc = RESET_PC.
  - FIFO empty; outstanding = 0; stale = 0.
  - imem_req_valid = 0; instr_valid = 0.
  - instr, instr_op, instr_pc, instr_pc_plus4 = 0.
  - Reset mid-transaction abandons all in-flight requests. The bench must not return responses for pre-reset requests.
- **Request issue:**
  - imem_req_valid = !reset_cycle && (fifo_count + outstanding < FIFO_DEPTH).
  - imem_req_valid is a function of registered state only.
  - imem_req_addr = fetch_pc.
  - On handshake: fetch_pc += 4 (wraps 32'hFFFF_FFFC → 0); outstanding += 1.
- **Response:**
  - Each imem_resp_valid decrements outstanding.
  - If stale > 0: word discarded, stale -= 1.
  - Otherwise: push {data, pc} into FIFO. The pc comes from an internal per-entry address record captured at issue.
  - Overflow is impossible by the credit rule; an assertion checks it.
- **Output:**
  - instr_valid = FIFO non-empty.
  - Head fields are registered FIFO contents and read 0 when empty.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle is legal at any occupancy, including full and empty with a bypass-free FIFO. Latency from response to instr_valid is 1 cycle.
- **Redirect (highest priority):** effects take place at the clock edge.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - FIFO cleared; any same-cycle pop or push has no effect.
  - stale ← outstanding (post-update), i.e. includes a request accepted in the redirect cycle and excludes a response arriving in the redirect cycle (that response is discarded).
  - Fetch resumes the next cycle, subject to credit.
  - Back-to-back redirects: each one restarts fetch; stale accumulates correctly.
- **Counters:** outstanding and stale are $clog2(FIFO_DEPTH)+1 bits wide and never exceed FIFO_DEPTH.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, the block adds outputs perf_fetched [31:0], perf_flushed [31:0], and perf_starved [31:0]:
  - perf_fetched counts FIFO pops.
  - perf_flushed counts discarded words: stale responses, FIFO entries cleared, and responses dropped in the redirect cycle.
  - perf_starved counts cycles with instr_ready=1 && instr_valid=0.
  - All three reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- **Reset start:** RESET_PC=32'h100, memory always ready, 1-cycle latency, instr_ready=1. Required: requests 0x100, 0x104, 0x108…; first instr_valid 2 cycles after the first accept; instr_pc sequence 0x100, 0x104; instr_pc_plus4 = 0x104, 0x108.
- **Backpressure:** instr_ready=0 with FIFO_DEPTH=2. Required: exactly 2 requests are issued, then imem_req_valid stays 0. Raising instr_ready for 1 cycle pops 0x100 and allows exactly one new request.
- **Redirect with stale responses:** redirect with redirect_pc=32'h203 while 2 requests are outstanding. Required: the next request address is 0x200; the 2 old responses are dropped; first instr_pc after the redirect is 0x200.
- **Same-cycle corner:** redirect coincides with a request handshake and a response. Required: the response is discarded, the accepted request is marked stale, and no pre-redirect PC ever appears on instr_pc.
- **Wrap-around:** RESET_PC=32'hFFFF_FFFC. Required: addresses FFFF_FFFC then 0000_0000; instr_pc_plus4 reads 0 for the first instruction.
- **FETCH_PERF_EN:** run the redirect-with-stale-responses scenario. Required: perf_flushed=2; perf_fetched equals the number of pops; with no memory response for 5 cycles and instr_ready=1, perf_starved increases by 5.
